// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with a 2-flop input synchroniser, mid-bit sampling FSM and a
// byte FIFO that the consumer pops with a single-cycle read pulse.
module uart_rx_fifo #(
   parameter int FIFO_DEPTH = 16
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [15:0]                   baud_div,
   input  logic                          uart_rx_pin,
   input  logic                          uart_rx_read,
   output logic                          uart_rx_ready,
   output logic [7:0]                    uart_rx_byte,
   output logic [$clog2(FIFO_DEPTH):0]   uart_rx_count,
   output logic                          uart_rx_overflow,
   output logic                          uart_rx_frame_err
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_BREAK
   } state_t;

   logic             rx_meta;
   logic             rx_s;

   state_t           state_q,  state_d;
   logic [15:0]      timer_q,  timer_d;
   logic [15:0]      baud_q,   baud_d;
   logic [2:0]       idx_q,    idx_d;
   logic [7:0]       shift_q,  shift_d;
   logic             byte_done;
   logic             frame_bad;
   logic             tick;

   logic [7:0]       mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic             full;
   logic             push;
   logic             pop;
   logic             drop;

   // Preset to 1 so reset looks like an idle line rather than a start bit.
   // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= uart_rx_pin;
         rx_s    <= rx_meta;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         timer_q <= '0;
         baud_q  <= '0;
         idx_q   <= '0;
         shift_q <= '0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         baud_q  <= baud_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
      end
   end

   assign tick = (timer_q == 16'd0);

   // The IDLE load of half-bit minus 2 lands the first sample floor(baud/2) cycles
   // after rx_s fell; later reloads of baud-1 space samples exactly baud_div apart.
   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      state_d   = state_q;
      timer_d   = timer_q;
      baud_d    = baud_q;
      idx_d     = idx_q;
      shift_d   = shift_q;
      byte_done = 1'b0;
      frame_bad = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (!rx_s && (baud_div >= 16'd4)) begin
               baud_d  = baud_div;
               timer_d = (baud_div >> 1) - 16'd2;
               state_d = S_START;
            end
         end
         S_START: begin
            if (!tick) begin
               timer_d = timer_q - 16'd1;
            end else if (rx_s) begin
               state_d = S_IDLE;
            end else begin
               timer_d = baud_q - 16'd1;
               idx_d   = 3'd0;
               state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (!tick) begin
               timer_d = timer_q - 16'd1;
            end else begin
               shift_d = {rx_s, shift_q[7:1]};
               timer_d = baud_q - 16'd1;
               idx_d   = idx_q + 3'd1;
               if (idx_q == 3'd7) state_d = S_STOP;
            end
         end
         S_STOP: begin
            if (!tick) begin
               timer_d = timer_q - 16'd1;
            end else if (rx_s) begin
               byte_done = 1'b1;
               state_d   = S_IDLE;
            end else begin
               frame_bad = 1'b1;
               state_d   = S_BREAK;
            end
         end
         S_BREAK: begin
            if (rx_s) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte.
   assign full = (count_q == CNT_W'(FIFO_DEPTH));
   assign pop  = uart_rx_read && (count_q != '0);
   assign push = byte_done && (!full || pop);
   assign drop = byte_done && full && !pop;

   // NOTE: the storage array has no reset; only pointers and count define validity.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr_q] <= shift_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q          <= '0;
         rd_ptr_q          <= '0;
         count_q           <= '0;
         uart_rx_byte      <= '0;
         uart_rx_overflow  <= 1'b0;
         uart_rx_frame_err <= 1'b0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop) begin
            rd_ptr_q     <= rd_ptr_q + PTR_W'(1);
            uart_rx_byte <= mem[rd_ptr_q];
         end
         unique case ({push, pop})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
         uart_rx_overflow  <= drop;
         uart_rx_frame_err <= frame_bad;
      end
   end

   assign uart_rx_ready = (count_q != '0);
   assign uart_rx_count = count_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomised bench for uart_rx_fifo: a serial line driver plus a queue model of the
// bytes that must come out, with counters for overflow and framing-error pulses.
module tb_uart_rx_fifo;

   localparam int DEPTH = 16;

   logic       clk;
   logic       rst_n;
   logic [15:0] baud_div;
   logic       uart_rx_pin;
   logic       uart_rx_read;
   logic       uart_rx_ready;
   logic [7:0] uart_rx_byte;
   logic [4:0] uart_rx_count;
   logic       uart_rx_overflow;
   logic       uart_rx_frame_err;

   int errors = 0;
   int checks = 0;

   logic [7:0] q[$];
   logic [7:0] last_byte = 8'h00;
   int exp_ovf = 0, exp_ferr = 0;
   int ovf_seen = 0, ferr_seen = 0;

   uart_rx_fifo #(.FIFO_DEPTH(DEPTH)) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .baud_div          (baud_div),
      .uart_rx_pin       (uart_rx_pin),
      .uart_rx_read      (uart_rx_read),
      .uart_rx_ready     (uart_rx_ready),
      .uart_rx_byte      (uart_rx_byte),
      .uart_rx_count     (uart_rx_count),
      .uart_rx_overflow  (uart_rx_overflow),
      .uart_rx_frame_err (uart_rx_frame_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Each cycle a pulse is high counts once, so a stretched pulse shows up as an extra event.
   always @(negedge clk) begin
      if (rst_n) begin
         if (uart_rx_overflow)  ovf_seen++;
         if (uart_rx_frame_err) ferr_seen++;
      end
   end

   initial begin
      repeat (90000) @(posedge clk);
      $display("FAIL timeout: simulation exceeded cycle budget");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Called at posedge+1; drives one 8N1 frame of bd cycles per bit and returns at the
   // end of the stop bit, so consecutive calls are back-to-back.
   task automatic send_frame(input logic [7:0] b, input int bd, input logic stop);
      baud_div    = 16'(bd);
      uart_rx_pin = 1'b0;
      for (int i = 0; i < 8; i++) begin
         repeat (bd) @(posedge clk);
         #1 uart_rx_pin = b[i];
      end
      repeat (bd) @(posedge clk);
      #1 uart_rx_pin = stop;
      repeat (bd) @(posedge clk);
      #1 uart_rx_pin = 1'b1;
   endtask

   task automatic model_push(input logic [7:0] b);
      if (q.size() < DEPTH) q.push_back(b);
      else exp_ovf++;
   endtask

   task automatic good_frame(input logic [7:0] b, input int bd);
      send_frame(b, bd, 1'b1);
      model_push(b);
   endtask

   task automatic do_read(input string tag);
      logic [7:0] e;
      e = (q.size() > 0) ? q.pop_front() : last_byte;
      last_byte = e;
      uart_rx_read = 1'b1;
      @(posedge clk);
      #1 uart_rx_read = 1'b0;
      check({tag, "_byte"}, 32'(uart_rx_byte), 32'(e));
      check({tag, "_count"}, 32'(uart_rx_count), 32'(q.size()));
   endtask

   task automatic check_pulses(input string tag);
      check({tag, "_ovf"}, 32'(ovf_seen), 32'(exp_ovf));
      check({tag, "_ferr"}, 32'(ferr_seen), 32'(exp_ferr));
   endtask

   initial begin
      int bd, h, k;
      logic [7:0] b;
      logic [7:0] oldest;

      rst_n        = 1'b0;
      uart_rx_pin  = 1'b1;
      uart_rx_read = 1'b0;
      baud_div     = 16'd868;
      #23;
      check("rst_ready", 32'(uart_rx_ready), 0);
      check("rst_count", 32'(uart_rx_count), 0);
      check("rst_byte",  32'(uart_rx_byte), 0);
      check("rst_ovf",   32'(uart_rx_overflow), 0);
      check("rst_ferr",  32'(uart_rx_frame_err), 0);
      rst_n = 1'b1;
      idle(3);

      // Two bytes at 868 clk/bit, then two pops.
      good_frame(8'h55, 868);
      good_frame(8'hA3, 868);
      check("t1_count", 32'(uart_rx_count), 2);
      check("t1_ready", 32'(uart_rx_ready), 1);
      do_read("t1_rd0");
      do_read("t1_rd1");
      check("t1_ready_end", 32'(uart_rx_ready), 0);
      do_read("t1_rd_empty");

      // Seventeen bytes with no reads: exactly one overflow.
      for (int i = 0; i <= 16; i++) good_frame(8'(i), 8);
      idle(2);
      check("t2_count", 32'(uart_rx_count), 16);
      check_pulses("t2");
      for (int i = 0; i < 16; i++) do_read("t2_drain");

      // Stop bit low: framing error, then a clean frame after release.
      send_frame(8'h3C, 12, 1'b0);
      exp_ferr++;
      idle(4);
      check("t3_count", 32'(uart_rx_count), 0);
      check_pulses("t3");
      good_frame(8'h7E, 12);
      do_read("t3_rd");

      // 200-cycle glitch at 868: rejected silently, receiver still usable.
      baud_div    = 16'd868;
      uart_rx_pin = 1'b0;
      idle(200);
      uart_rx_pin = 1'b1;
      idle(700);
      check("t4_count", 32'(uart_rx_count), 0);
      check_pulses("t4");
      good_frame(8'hC5, 16);
      do_read("t4_rd");

      // Start condition with an unsupported divider is ignored.
      baud_div    = 16'd3;
      uart_rx_pin = 1'b0;
      idle(40);
      uart_rx_pin = 1'b1;
      idle(10);
      check("slow_count", 32'(uart_rx_count), 0);
      check_pulses("slow");

      // Full FIFO with a pop coinciding with the 17th stop-bit sample.
      for (int i = 0; i < 16; i++) good_frame(8'(8'h40 + i), 8);
      check("t5_full", 32'(uart_rx_count), 16);
      bd = 10;
      h  = bd / 2;
      k  = 1 + h + 9 * bd;
      fork
         send_frame(8'hEE, bd, 1'b1);
         begin
            repeat (k) @(posedge clk);
            #1 uart_rx_read = 1'b1;
            @(posedge clk);
            #1 uart_rx_read = 1'b0;
            oldest = q.pop_front();
            last_byte = oldest;
            check("t5_byte", 32'(uart_rx_byte), 32'(oldest));
            check("t5_count", 32'(uart_rx_count), 16);
         end
      join
      q.push_back(8'hEE);
      idle(2);
      check("t5_count_after", 32'(uart_rx_count), 16);
      check_pulses("t5");
      while (q.size() > 0) do_read("t5_drain");

      // Random frames, dividers, framing errors and read bursts.
      for (int n = 0; n < 24; n++) begin
         bd = $urandom_range(4, 24);
         b  = 8'($urandom);
         if ($urandom_range(0, 5) == 0) begin
            send_frame(b, bd, 1'b0);
            exp_ferr++;
            idle(bd);
         end else begin
            good_frame(b, bd);
         end
         check("rnd_count", 32'(uart_rx_count), 32'(q.size()));
         for (int r = $urandom_range(0, 2); r > 0; r--) do_read("rnd_rd");
      end
      check_pulses("rnd");

      // Reset mid-frame with three bytes queued and a nonzero output byte.
      while (q.size() > 0) do_read("t6_pre");
      for (int i = 0; i < 4; i++) good_frame(8'(8'h90 + i), 8);
      do_read("t6_rd0");
      check("t6_queued", 32'(uart_rx_count), 3);
      baud_div    = 16'd8;
      uart_rx_pin = 1'b0;
      idle(30);
      rst_n = 1'b0;
      #1;
      check("t6_ready", 32'(uart_rx_ready), 0);
      check("t6_count", 32'(uart_rx_count), 0);
      check("t6_byte",  32'(uart_rx_byte), 0);
      q.delete();
      last_byte   = 8'h00;
      uart_rx_pin = 1'b1;
      #22 rst_n = 1'b1;
      idle(3);
      good_frame(8'h81, 8);
      check("t6_count_after", 32'(uart_rx_count), 1);
      do_read("t6_rd");
      check("t6_ready_end", 32'(uart_rx_ready), 0);
      check_pulses("t6");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
